// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder response checker.
// The signature feature is only compiled when ADDER_CHK_MISR_EN is defined.
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // One MISR step: shift, fold the feedback polynomial, then mix in new data.
    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] data);
        return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ data;
    endfunction

endpackage

// File: rtl/adder_chk_misr.sv
// 16-bit multiple-input signature register compressing the DUT responses.
// Instantiated only when ADDER_CHK_MISR_EN is defined.
module adder_chk_misr
    import adder_chk_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_seed,
    input  logic        i_en,
    input  logic [15:0] i_data,
    output logic [15:0] o_sig
);

    logic [15:0] r_sig;

    // Seed has priority so a restart never folds the discarded sample in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig <= MISR_SEED;
        end else if (i_seed) begin
            r_sig <= MISR_SEED;
        end else if (i_en) begin
            r_sig <= misr_step(r_sig, i_data);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/adder_response_checker.sv
// Response analyser for an exhaustive adder sweep: compares {c_out,sum} to a+b,
// counts vectors and mismatches, latches the first failure. ADDER_CHK_MISR_EN adds o_signature.
module adder_response_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int EXP_VECTORS = 2**(2*WIDTH),
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_vld,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [WIDTH-1:0]     i_sum,
    input  logic                 i_c_out,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [2*WIDTH:0]     o_vec_cnt,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic                 o_first_err_vld,
    output logic [WIDTH-1:0]     o_first_err_a,
    output logic [WIDTH-1:0]     o_first_err_b
`ifdef ADDER_CHK_MISR_EN
    ,output logic [15:0]         o_signature
`endif
);

    localparam int VW = 2*WIDTH + 1;
    localparam logic [VW-1:0] EXP_CNT = VW'(EXP_VECTORS);

    state_e               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [VW-1:0]        r_vec_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_first_err_vld;
    logic [WIDTH-1:0]     r_first_err_a;
    logic [WIDTH-1:0]     r_first_err_b;

    logic [WIDTH:0]       w_expected;
    logic                 w_mismatch;
    logic                 w_accept;
    logic [VW-1:0]        w_vec_nxt;
    logic [ERR_CNT_W-1:0] w_err_nxt;

    // Golden adder, zero-extended so the carry is compared too.
    assign w_expected = {1'b0, i_a} + {1'b0, i_b};
    assign w_mismatch = ({i_c_out, i_sum} != w_expected);
    // A coincident start discards the sample.
    assign w_accept   = (r_state == RUN) && i_vld && !i_start;
    assign w_vec_nxt  = r_vec_cnt + VW'(1);
    assign w_err_nxt  = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + ERR_CNT_W'(1) : r_err_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_vec_cnt       <= '0;
            r_err_cnt       <= '0;
            r_first_err_vld <= 1'b0;
            r_first_err_a   <= '0;
            r_first_err_b   <= '0;
        end else if (i_start) begin
            r_state         <= RUN;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_vec_cnt       <= '0;
            r_err_cnt       <= '0;
            r_first_err_vld <= 1'b0;
            r_first_err_a   <= '0;
            r_first_err_b   <= '0;
        end else if (w_accept) begin
            r_vec_cnt <= w_vec_nxt;
            r_err_cnt <= w_err_nxt;
            if (w_mismatch && !r_first_err_vld) begin
                r_first_err_vld <= 1'b1;
                r_first_err_a   <= i_a;
                r_first_err_b   <= i_b;
            end
            // Pass uses the updated count so a fault on the last vector still fails.
            if (w_vec_nxt == EXP_CNT) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_pass  <= (w_err_nxt == '0);
            end
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_vec_cnt       = r_vec_cnt;
    assign o_err_cnt       = r_err_cnt;
    assign o_first_err_vld = r_first_err_vld;
    assign o_first_err_a   = r_first_err_a;
    assign o_first_err_b   = r_first_err_b;

`ifdef ADDER_CHK_MISR_EN
    logic [15:0] w_misr_data;
    assign w_misr_data = 16'({i_c_out, i_sum});

    adder_chk_misr u_misr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_seed  (i_start),
        .i_en    (w_accept),
        .i_data  (w_misr_data),
        .o_sig   (o_signature)
    );
`endif

endmodule

// File: tb/tb_adder_response_checker.sv
// Randomized bench for adder_response_checker against a behavioural model.
// Two instances share stimulus: default ERR_CNT_W and ERR_CNT_W=4 for saturation.
module tb_adder_response_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, vld, c_out;
    logic [3:0] a, b, sum;

    logic       busy, done, pass, fev;
    logic [8:0] vec;
    logic [7:0] err;
    logic [3:0] fea, feb;
    logic       busy4, done4, pass4, fev4;
    logic [8:0] vec4;
    logic [3:0] err4;
    logic [3:0] fea4, feb4;
`ifdef ADDER_CHK_MISR_EN
    logic [15:0] sig, sig4;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adder_response_checker dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_vld(vld),
        .i_a(a), .i_b(b), .i_sum(sum), .i_c_out(c_out),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_vec_cnt(vec), .o_err_cnt(err),
        .o_first_err_vld(fev), .o_first_err_a(fea), .o_first_err_b(feb)
`ifdef ADDER_CHK_MISR_EN
        , .o_signature(sig)
`endif
    );

    adder_response_checker #(.ERR_CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_vld(vld),
        .i_a(a), .i_b(b), .i_sum(sum), .i_c_out(c_out),
        .o_busy(busy4), .o_done(done4), .o_pass(pass4), .o_vec_cnt(vec4), .o_err_cnt(err4),
        .o_first_err_vld(fev4), .o_first_err_a(fea4), .o_first_err_b(feb4)
`ifdef ADDER_CHK_MISR_EN
        , .o_signature(sig4)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy, m_done, m_pass, m_fv;
    int          m_vec, m_err, m_exp, m_got;
    logic [3:0]  m_fa, m_fb;
    logic [15:0] m_sig;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_pass = 0; m_fv = 0;
            m_vec = 0; m_err = 0; m_fa = 0; m_fb = 0; m_sig = 16'hFFFF;
        end else if (start) begin
            m_busy = 1; m_done = 0; m_pass = 0; m_fv = 0;
            m_vec = 0; m_err = 0; m_fa = 0; m_fb = 0; m_sig = 16'hFFFF;
        end else if (m_busy && vld) begin
            m_exp = int'(a) + int'(b);
            m_got = int'(c_out) * 16 + int'(sum);
            m_vec = m_vec + 1;
            if (m_got != m_exp) begin
                m_err = m_err + 1;
                if (!m_fv) begin m_fv = 1; m_fa = a; m_fb = b; end
            end
            m_sig = ((m_sig << 1) ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ 16'(m_got)) & 16'hFFFF;
            if (m_vec == 256) begin
                m_busy = 0; m_done = 1; m_pass = (m_err == 0);
            end
        end
    end

    // One compare process, every cycle, away from the active edge.
    always @(posedge clk) begin
        #1;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("pass", pass, m_pass);
        chk("vec_cnt", vec, m_vec);
        chk("err_cnt", err, (m_err > 255) ? 255 : m_err);
        chk("first_err_vld", fev, m_fv);
        chk("first_err_a", fea, m_fa);
        chk("first_err_b", feb, m_fb);
        chk("busy4", busy4, m_busy);
        chk("done4", done4, m_done);
        chk("pass4", pass4, m_pass);
        chk("vec_cnt4", vec4, m_vec);
        chk("err_cnt4", err4, (m_err > 15) ? 15 : m_err);
        chk("first_err4", {fev4, fea4, feb4}, {m_fv, m_fa, m_fb});
`ifdef ADDER_CHK_MISR_EN
        chk("signature", sig, m_sig);
        chk("signature4", sig4, m_sig);
`endif
    end

    // ---------------- stimulus ----------------
    // mode 0 correct, 1 faults at (3,5)->9 and (7,7)->0, 2 carry fault at (15,1), 3 all wrong
    function automatic logic [4:0] answer(input logic [3:0] x, input logic [3:0] y, input int mode);
        logic [4:0] r;
        r = {1'b0, x} + {1'b0, y};
        case (mode)
            1: begin
                if (x == 4'd3 && y == 4'd5) r = 5'd9;
                if (x == 4'd7 && y == 4'd7) r = 5'd0;
            end
            2: if (x == 4'd15 && y == 4'd1) r = 5'd0;
            3: r = r + 5'd1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic idle();
        @(negedge clk); start = 0; vld = 0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1; vld = 0;
    endtask

    task automatic send(input logic [3:0] x, input logic [3:0] y, input int mode);
        @(negedge clk);
        start = 0; vld = 1; a = x; b = y;
        {c_out, sum} = answer(x, y, mode);
    endtask

    task automatic sweep(input int mode, input bit gaps);
        for (int i = 0; i < 256; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) idle();
            send(4'(i >> 4), 4'(i & 15), mode);
        end
    endtask

    initial begin
        rst_n = 0; start = 0; vld = 0; a = 0; b = 0; sum = 0; c_out = 0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset outs", {done, pass, vec, err, fev, fea, feb}, 0);
        rst_n = 1;

        // 1: clean ascending sweep with random gaps
        do_start(); sweep(0, 1); idle();
        chk("t1 done", done, 1);
        chk("t1 vec", vec, 256);
        chk("t1 err", err, 0);
        chk("t1 pass", pass, 1);
        chk("t1 fev", fev, 0);
        for (int i = 0; i < 5; i++) send(4'($urandom), 4'($urandom), 3);
        idle();
        chk("t1 done ignores vld", {vec, err}, {9'd256, 8'd0});

        // 2: two faults, first one latched
        do_start(); sweep(1, 0); idle();
        chk("t2 err", err, 2);
        chk("t2 first a", fea, 3);
        chk("t2 first b", feb, 5);
        chk("t2 pass", pass, 0);

        // 3: carry fault
        do_start(); sweep(2, 1); idle();
        chk("t3 err", err, 1);
        chk("t3 first", {fea, feb}, {4'd15, 4'd1});
        chk("t3 pass", {done, pass}, 2'b10);

        // 4: gap holds counters; start with vld drops sample
        do_start();
        for (int i = 0; i < 20; i++) send(4'($urandom), 4'($urandom), 0);
        repeat (10) idle();
        chk("t4 gap vec", vec, 20);
        @(negedge clk); start = 1; vld = 1; a = 4'd3; b = 4'd5; {c_out, sum} = answer(3, 5, 1);
        idle();
        chk("t4 start+vld", {busy, vec, err, fev}, {1'b1, 9'd0, 8'd0, 1'b0});

        // 5: reset mid-run then clean sweep
        do_start();
        for (int i = 0; i < 100; i++) send(4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 3 : 0);
        @(negedge clk); vld = 0; rst_n = 0;
        #1;
        chk("t5 reset outs", {busy, done, pass, vec, err, fev, fea, feb}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        do_start(); sweep(0, 1); idle();
        chk("t5 vec", vec, 256);
        chk("t5 pass", pass, 1);

        // random operands and random faults, count-only coverage
        do_start();
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 5) == 0) idle();
            send(4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0) ? 3 : 0);
        end
        idle();
        chk("rand done", done, 1);

        // 6: every answer wrong, saturation on the narrow counter
        do_start(); sweep(3, 0); idle();
        chk("t6 err4 sat", err4, 15);
        chk("t6 err8 sat", err, 255);
        chk("t6 pass", {pass, pass4}, 2'b00);

`ifdef ADDER_CHK_MISR_EN
        do_start(); send(0, 0, 0); idle();
        chk("misr one step", sig, 16'hEFDF);
        do_start(); sweep(0, 1); idle();
        chk("misr done held", done, 1);
`endif

        repeat (2) idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
